// File: rtl/game_controller_if.sv
// Command/status bus between the game controller and the memory-game datapath.
// Master drives the commands; the datapath reports its status flags.
interface game_controller_if;
  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;
  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  modport master (
    output r1, r2, e1, e2, e3, e4, sel,
    input  end_fpga, end_user, end_time, win, match
  );

  modport slave (
    input  r1, r2, e1, e2, e3, e4, sel,
    output end_fpga, end_user, end_time, win, match
  );
endinterface

// File: rtl/game_controller.sv
// Memory-game control FSM with synchronized, edge-detected push buttons.
// Sequences the datapath through setup, playback, user play and result.
module game_controller #(
  parameter int P_KEY       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic [P_KEY-1:0]         key,
  game_controller_if.master        dp,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_SETUP  = 3'd1,
    S_SEQ    = 3'd2,
    S_PLAY   = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_RCHK   = 3'd6,
    S_RESULT = 3'd7
  } state_e;

  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][P_KEY-1:0] sync_q, sync_d;
  logic [P_KEY-1:0] prev_q, prev_d;
  logic [P_KEY-1:0] press_q, press_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             r2_pls_q, r2_pls_d;
  state_e           state_q, state_d;

  logic enter_p;
  logic play_p;
  logic r1, r2, e1, e2, e3, e4, sel;

  // Edges are masked until the chain holds real samples, so a button
  // held through reset release never looks like a fresh press.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], key};
    prev_d   = sync_q[SYNC_STAGES-1];
    settle_d = (settle_q == SETTLED) ? settle_q : settle_q + 1'b1;
    press_d  = '0;
    if (settle_q == SETTLED) begin
      press_d = prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign enter_p = press_q[0];
  assign play_p  = |press_q[P_KEY-1:1];

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      prev_q   <= '1;
      press_q  <= '0;
      settle_q <= '0;
      r2_pls_q <= 1'b0;
      state_q  <= S_INIT;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      settle_q <= settle_d;
      r2_pls_q <= r2_pls_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r1       = 1'b0;
    r2       = r2_pls_q;
    e1       = 1'b0;
    e2       = 1'b0;
    e3       = 1'b0;
    e4       = 1'b0;
    sel      = 1'b0;
    r2_pls_d = (state_q == S_SEQ) && dp.end_fpga;
    case (state_q)
      S_INIT: begin
        r1      = 1'b1;
        r2      = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        e1 = 1'b1;
        r2 = 1'b1;
        if (enter_p) state_d = S_SEQ;
      end
      S_SEQ: begin
        e3 = 1'b1;
        if (dp.end_fpga) state_d = S_PLAY;
      end
      S_PLAY: begin
        e2 = 1'b1;
        e3 = play_p && !dp.end_time;
        if (dp.end_time) state_d = S_RESULT;
        else if (play_p) state_d = S_CHECK;
      end
      S_CHECK: begin
        e2 = 1'b1;
        if (!dp.match)        state_d = S_RESULT;
        else if (dp.end_user) state_d = S_NEXT;
        else                  state_d = S_PLAY;
      end
      S_NEXT: begin
        e4      = 1'b1;
        r2      = 1'b1;
        state_d = S_RCHK;
      end
      S_RCHK: begin
        state_d = dp.win ? S_RESULT : S_SEQ;
      end
      S_RESULT: begin
        sel = 1'b1;
        if (enter_p) state_d = S_INIT;
      end
      default: begin
        r1      = 1'b1;
        r2      = 1'b1;
        state_d = S_INIT;
      end
    endcase
  end

  assign dp.r1  = r1;
  assign dp.r2  = r2;
  assign dp.e1  = e1;
  assign dp.e2  = e2;
  assign dp.e3  = e3;
  assign dp.e4  = e4;
  assign dp.sel = sel;
  assign state  = state_q;

endmodule
